// File: rtl/btb_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : btb_ctrl_pkg
// Purpose  : Shared definitions for the BTB controller: default widths,
//            BTB entry field layout {valid, tag, target} and FSM states.
// Ports    : none (package)
// Options  : BTB_FWD_EN (consumed by btb_ctrl / btb_wq, not used here)
// Revision : 1.0 - initial release
// ============================================================================
package btb_ctrl_pkg;

   localparam int c_btb_pc_w    = 13;                         // word-PC width
   localparam int c_btb_idx_w   = 11;                         // 2048 entries
   localparam int c_btb_tag_w   = c_btb_pc_w - c_btb_idx_w;   // 2
   localparam int c_btb_entry_w = 1 + c_btb_tag_w + c_btb_pc_w;  // 16

   // Entry layout: [15] valid, [14:13] tag (pc[12:11]), [12:0] target
   localparam int c_valid_bit = c_btb_entry_w - 1;
   localparam int c_tag_msb   = c_btb_entry_w - 2;
   localparam int c_tag_lsb   = c_btb_pc_w;
   localparam int c_tgt_msb   = c_btb_pc_w - 1;
   localparam int c_tgt_lsb   = 0;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,   // clear sweep in progress
      ST_RUN  = 1'b1    // normal lookup / update service
   } btb_state_t;

endpackage
`default_nettype wire

// File: rtl/btb_ctrl_wq.sv
`default_nettype none
// ============================================================================
// Module   : btb_wq
// Purpose  : Dual-enqueue, single-dequeue FIFO holding pending BTB updates.
//            Lane 0 is enqueued ahead of lane 1 in the same cycle. A slot
//            freed by a same-cycle dequeue is reusable immediately.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            clr               - discard all entries (wins over enqueue)
//            wen0/addr0/data0  - lane-0 enqueue request
//            wen1/addr1/data1  - lane-1 enqueue request
//            deq               - pop head (caller guarantees non-empty)
//            head_addr/data    - oldest entry
//            count             - number of valid entries
//            acc0/acc1         - lane request accepted this cycle
//            ent_addr/data/valid - entries in age order, index 0 oldest
//                                (present only with BTB_FWD_EN)
// Options  : BTB_FWD_EN adds the ent_* forwarding ports.
// Revision : 1.0 - initial release
// ============================================================================
module btb_wq #(
   parameter int DEPTH = 4,    // power of two, >= 2
   parameter int AW    = 11,
   parameter int DW    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      wen0,
   input  logic [AW-1:0]             addr0,
   input  logic [DW-1:0]             data0,
   input  logic                      wen1,
   input  logic [AW-1:0]             addr1,
   input  logic [DW-1:0]             data1,
   input  logic                      deq,
   output logic [AW-1:0]             head_addr,
   output logic [DW-1:0]             head_data,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      acc0,
   output logic                      acc1
`ifdef BTB_FWD_EN
   ,
   output logic [DEPTH-1:0][AW-1:0]  ent_addr,
   output logic [DEPTH-1:0][DW-1:0]  ent_data,
   output logic [DEPTH-1:0]          ent_valid
`endif
);

   localparam int c_pw = $clog2(DEPTH);
   localparam int c_cw = c_pw + 1;
   localparam logic [c_cw:0] c_depth = (c_cw+1)'(DEPTH);

   logic [AW-1:0]   r_addr [DEPTH];
   logic [DW-1:0]   r_data [DEPTH];
   logic [c_pw-1:0] r_rd;
   logic [c_pw-1:0] r_wr;
   logic [c_cw-1:0] r_cnt;

   logic [c_cw:0]   w_free;
   logic [1:0]      w_nacc;
   logic [c_pw-1:0] w_wi1;

   // Free slots include the one vacated by this cycle's dequeue.
   assign w_free = c_depth - {1'b0, r_cnt} + {{c_cw{1'b0}}, deq};
   assign acc0   = wen0 && (w_free != '0);
   assign acc1   = wen1 && (w_free > {{c_cw{1'b0}}, acc0});
   assign w_nacc = {1'b0, acc0} + {1'b0, acc1};
   // Lane 1 lands behind lane 0 when both are accepted.
   assign w_wi1  = r_wr + c_pw'(acc0);

   assign head_addr = r_addr[r_rd];
   assign head_data = r_data[r_rd];
   assign count     = r_cnt;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         r_rd  <= r_rd + c_pw'(deq);
         r_wr  <= r_wr + c_pw'(w_nacc);
         r_cnt <= r_cnt + c_cw'(w_nacc) - c_cw'(deq);
      end
   end

   // Storage is not reset; occupancy is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (acc0) begin
         r_addr[r_wr] <= addr0;
         r_data[r_wr] <= data0;
      end
      if (acc1) begin
         r_addr[w_wi1] <= addr1;
         r_data[w_wi1] <= data1;
      end
   end

`ifdef BTB_FWD_EN
   for (genvar k = 0; k < DEPTH; k++) begin : g_age
      logic [c_pw-1:0] w_slot;
      assign w_slot       = r_rd + c_pw'(k);
      assign ent_addr[k]  = r_addr[w_slot];
      assign ent_data[k]  = r_data[w_slot];
      assign ent_valid[k] = (c_cw'(k) < r_cnt);
   end
`endif

endmodule
`default_nettype wire

// File: rtl/btb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : btb_ctrl
// Purpose  : Controller for the 2048-entry branch target buffer RAM.
//            Fetch lookups own the single RAM port; updates from two execute
//            lanes are queued and written in idle cycles. A clear sweep zeroes
//            the RAM after reset and on btb_clear.
// Ports    : clk, rst                  - clock, sync active-high reset
//            btb_clear                 - restart sweep, discard queue
//            fetch_req, fetch_pc       - lookup request
//            pred_valid/hit/pc         - lookup result, cycle after request
//            upd_wen*/upd_addr*/upd_data* - lane 0/1 table updates
//            ram_addr/wdata/we, ram_rdata - BTB RAM (1-cycle read latency)
//            ready                     - sweep finished
//            overflow                  - an update was dropped this cycle
// Options  : BTB_FWD_EN - lookups see queued and same-cycle updates.
// Revision : 1.0 - initial release
// ============================================================================
module btb_ctrl
   import btb_ctrl_pkg::*;
#(
   parameter int QDEPTH = 4,
   parameter int PC_W   = c_btb_pc_w,
   parameter int IDX_W  = c_btb_idx_w
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     btb_clear,
   input  logic                     fetch_req,
   input  logic [PC_W-1:0]          fetch_pc,
   output logic                     pred_valid,
   output logic                     pred_hit,
   output logic [PC_W-1:0]          pred_pc,
   input  logic                     upd_wen0,
   input  logic [IDX_W-1:0]         upd_addr0,
   input  logic [c_btb_entry_w-1:0] upd_data0,
   input  logic                     upd_wen1,
   input  logic [IDX_W-1:0]         upd_addr1,
   input  logic [c_btb_entry_w-1:0] upd_data1,
   output logic [IDX_W-1:0]         ram_addr,
   output logic [c_btb_entry_w-1:0] ram_wdata,
   output logic                     ram_we,
   input  logic [c_btb_entry_w-1:0] ram_rdata,
   output logic                     ready,
   output logic                     overflow
);

   localparam int c_cw = $clog2(QDEPTH) + 1;

   btb_state_t               r_state;
   btb_state_t               w_state_nxt;
   logic [IDX_W-1:0]         r_cnt;
   logic [IDX_W-1:0]         w_cnt_nxt;

   logic                     w_deq;
   logic [IDX_W-1:0]         w_head_addr;
   logic [c_btb_entry_w-1:0] w_head_data;
   logic [c_cw-1:0]          w_count;
   logic                     w_acc0;
   logic                     w_acc1;

   // Lookup context captured with the RAM read
   logic                     r_lkp_vld;
   logic                     r_lkp_run;
   logic [PC_W-1:0]          r_lkp_pc;
   logic [c_btb_entry_w-1:0] w_rdata;
   logic                     w_hit;

`ifdef BTB_FWD_EN
   logic [QDEPTH-1:0][IDX_W-1:0]         w_ent_addr;
   logic [QDEPTH-1:0][c_btb_entry_w-1:0] w_ent_data;
   logic [QDEPTH-1:0]                    w_ent_valid;
   logic                                 w_fwd_hit;
   logic [c_btb_entry_w-1:0]             w_fwd_data;
   logic                                 r_fwd_hit;
   logic [c_btb_entry_w-1:0]             r_fwd_data;
`endif

   btb_wq #(
      .DEPTH (QDEPTH),
      .AW    (IDX_W),
      .DW    (c_btb_entry_w)
   ) u_wq (
      .clk       (clk),
      .rst       (rst),
      .clr       (btb_clear),
      .wen0      (upd_wen0),
      .addr0     (upd_addr0),
      .data0     (upd_data0),
      .wen1      (upd_wen1),
      .addr1     (upd_addr1),
      .data1     (upd_data1),
      .deq       (w_deq),
      .head_addr (w_head_addr),
      .head_data (w_head_data),
      .count     (w_count),
      .acc0      (w_acc0),
      .acc1      (w_acc1)
`ifdef BTB_FWD_EN
      ,
      .ent_addr  (w_ent_addr),
      .ent_data  (w_ent_data),
      .ent_valid (w_ent_valid)
`endif
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // ---------------- FSM: next state and RAM port ----------------
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_deq       = 1'b0;
      ram_we      = 1'b0;
      ram_addr    = fetch_pc[IDX_W-1:0];
      ram_wdata   = '0;
      case (r_state)
         ST_INIT: begin
            // Sweep never stalls; lookups in this state report a miss.
            ram_we    = 1'b1;
            ram_addr  = r_cnt;
            w_cnt_nxt = r_cnt + IDX_W'(1);
            if (&r_cnt) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            // A clearing cycle must not leak a queued write into the RAM.
            if (!fetch_req && (w_count != '0) && !btb_clear) begin
               ram_we    = 1'b1;
               ram_addr  = w_head_addr;
               ram_wdata = w_head_data;
               w_deq     = 1'b1;
            end
         end
         default: w_state_nxt = ST_INIT;
      endcase
      if (btb_clear) begin
         w_state_nxt = ST_INIT;
         w_cnt_nxt   = '0;
      end
      if (rst) begin
         ram_we = 1'b0;
         w_deq  = 1'b0;
      end
   end

   assign ready    = (r_state == ST_RUN);
   // Enqueues discarded by a clear are not counted as drops.
   assign overflow = !rst && !btb_clear &&
                     ((upd_wen0 && !w_acc0) || (upd_wen1 && !w_acc1));

   // ---------------- lookup pipeline ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lkp_vld <= 1'b0;
         r_lkp_run <= 1'b0;
         r_lkp_pc  <= '0;
      end else begin
         r_lkp_vld <= fetch_req;
         r_lkp_run <= (r_state == ST_RUN);
         r_lkp_pc  <= fetch_pc;
      end
   end

`ifdef BTB_FWD_EN
   // Youngest matching update wins: queue oldest..newest, then lane 0, lane 1.
   always_comb begin
      w_fwd_hit  = 1'b0;
      w_fwd_data = '0;
      for (int k = 0; k < QDEPTH; k++) begin
         if (w_ent_valid[k] && (w_ent_addr[k] == fetch_pc[IDX_W-1:0])) begin
            w_fwd_hit  = 1'b1;
            w_fwd_data = w_ent_data[k];
         end
      end
      if (w_acc0 && !btb_clear && (upd_addr0 == fetch_pc[IDX_W-1:0])) begin
         w_fwd_hit  = 1'b1;
         w_fwd_data = upd_data0;
      end
      if (w_acc1 && !btb_clear && (upd_addr1 == fetch_pc[IDX_W-1:0])) begin
         w_fwd_hit  = 1'b1;
         w_fwd_data = upd_data1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fwd_hit  <= 1'b0;
         r_fwd_data <= '0;
      end else begin
         r_fwd_hit  <= fetch_req && w_fwd_hit;
         r_fwd_data <= w_fwd_data;
      end
   end

   assign w_rdata = r_fwd_hit ? r_fwd_data : ram_rdata;
`else
   assign w_rdata = ram_rdata;
`endif

   assign w_hit = w_rdata[c_valid_bit] &&
                  (w_rdata[c_tag_msb:c_tag_lsb] == r_lkp_pc[PC_W-1:IDX_W]);

   always_comb begin
      pred_valid = r_lkp_vld;
      pred_hit   = r_lkp_vld && r_lkp_run && w_hit;
      pred_pc    = '0;
      if (r_lkp_vld) begin
         // Miss falls through to pc+1, wrapping modulo 2^PC_W.
         pred_pc = (r_lkp_run && w_hit) ? w_rdata[c_tgt_msb:c_tgt_lsb]
                                        : r_lkp_pc + PC_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_btb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_btb_ctrl
// Purpose  : Self-checking bench for btb_ctrl. Provides a behavioural BTB
//            RAM and a cycle reference model (expected table contents plus a
//            FIFO of pending updates) derived from the controller rules.
// Options  : BTB_FWD_EN - reference model includes update forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btb_ctrl;

   localparam int QD = 4;

   logic        clk;
   logic        rst;
   logic        btb_clear;
   logic        fetch_req;
   logic [12:0] fetch_pc;
   logic        pred_valid;
   logic        pred_hit;
   logic [12:0] pred_pc;
   logic        upd_wen0;
   logic [10:0] upd_addr0;
   logic [15:0] upd_data0;
   logic        upd_wen1;
   logic [10:0] upd_addr1;
   logic [15:0] upd_data1;
   logic [10:0] ram_addr;
   logic [15:0] ram_wdata;
   logic        ram_we;
   logic [15:0] ram_rdata;
   logic        ready;
   logic        overflow;

   int total = 0;
   int bad   = 0;

   // Behavioural RAM attached to the DUT
   logic [15:0] mem [2048];

   // Reference model state
   logic [15:0] m_btb [2048];
   logic [26:0] q [$];          // {addr[10:0], data[15:0]}
   bit          m_ready;
   int          m_sweep;
   bit          m_pv;
   bit          m_ph;
   logic [12:0] m_pp;

   btb_ctrl #(.QDEPTH(QD), .PC_W(13), .IDX_W(11)) dut (
      .clk        (clk),
      .rst        (rst),
      .btb_clear  (btb_clear),
      .fetch_req  (fetch_req),
      .fetch_pc   (fetch_pc),
      .pred_valid (pred_valid),
      .pred_hit   (pred_hit),
      .pred_pc    (pred_pc),
      .upd_wen0   (upd_wen0),
      .upd_addr0  (upd_addr0),
      .upd_data0  (upd_data0),
      .upd_wen1   (upd_wen1),
      .upd_addr1  (upd_addr1),
      .upd_data1  (upd_data1),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_we     (ram_we),
      .ram_rdata  (ram_rdata),
      .ready      (ready),
      .overflow   (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_idle();
      btb_clear = 1'b0;
      fetch_req = 1'b0;
      fetch_pc  = '0;
      upd_wen0  = 1'b0;
      upd_addr0 = '0;
      upd_data0 = '0;
      upd_wen1  = 1'b0;
      upd_addr1 = '0;
      upd_data1 = '0;
   endtask

   function automatic logic [15:0] rnd_entry();
      return 16'(((($urandom_range(0, 9) < 8) ? 1 : 0) << 15) |
                 ($urandom_range(0, 3) << 13) | $urandom_range(0, 8191));
   endfunction

   // Indices are kept inside 0x20..0x5F so directed entries stay untouched.
   task automatic rnd_inputs(input int unsigned pf, input int unsigned pw);
      fetch_req = ($urandom_range(0, 99) < pf);
      fetch_pc  = 13'(($urandom_range(0, 3) << 11) | $urandom_range(32, 95));
      upd_wen0  = ($urandom_range(0, 99) < pw);
      upd_addr0 = 11'($urandom_range(32, 95));
      upd_data0 = rnd_entry();
      upd_wen1  = ($urandom_range(0, 99) < pw);
      upd_addr1 = 11'($urandom_range(32, 95));
      upd_data1 = rnd_entry();
   endtask

   // One clock cycle: predict outputs from current inputs, check mid-cycle,
   // then advance the model across the edge. Returns at posedge + 1.
   task automatic cycle();
      bit          exp_we, chk_addr, deq, a0, a1, exp_ovf, nhit;
      logic [10:0] exp_addr;
      logic [15:0] exp_wd, ent;
      logic [12:0] npc;
      int          free;

      deq = 0; chk_addr = 1; exp_wd = '0; exp_addr = '0;
      if (!m_ready) begin
         exp_we = 1; exp_addr = 11'(m_sweep);
      end else if (fetch_req) begin
         exp_we = 0; exp_addr = fetch_pc[10:0];
      end else if (q.size() > 0 && !btb_clear) begin
         exp_we = 1; exp_addr = q[0][26:16]; exp_wd = q[0][15:0]; deq = 1;
      end else begin
         exp_we = 0; chk_addr = 0;
      end
      free = QD - q.size() + (deq ? 1 : 0);
      a0 = upd_wen0 && (free >= 1);
      if (a0) free--;
      a1 = upd_wen1 && (free >= 1);
      exp_ovf = !btb_clear && ((upd_wen0 && !a0) || (upd_wen1 && !a1));
      if (btb_clear) begin a0 = 0; a1 = 0; end

      @(negedge clk);
      chk("ready", ready, m_ready);
      chk("ram_we", ram_we, exp_we);
      if (chk_addr) chk("ram_addr", ram_addr, exp_addr);
      if (exp_we) chk("ram_wdata", ram_wdata, exp_wd);
      chk("overflow", overflow, exp_ovf);
      chk("pred_valid", pred_valid, m_pv);
      if (m_pv) begin
         chk("pred_hit", pred_hit, m_ph);
         chk("pred_pc", pred_pc, m_pp);
      end

      // Lookup result expected next cycle
      nhit = 0; ent = '0;
      if (fetch_req && m_ready) begin
         ent = m_btb[fetch_pc[10:0]];
`ifdef BTB_FWD_EN
         foreach (q[i]) if (q[i][26:16] == fetch_pc[10:0]) ent = q[i][15:0];
         if (a0 && upd_addr0 == fetch_pc[10:0]) ent = upd_data0;
         if (a1 && upd_addr1 == fetch_pc[10:0]) ent = upd_data1;
`endif
         nhit = ent[15] && (ent[14:13] == fetch_pc[12:11]);
      end
      npc = nhit ? ent[12:0] : fetch_pc + 13'd1;

      if (exp_we) m_btb[exp_addr] = exp_wd;
      if (deq) void'(q.pop_front());
      if (a0) q.push_back({upd_addr0, upd_data0});
      if (a1) q.push_back({upd_addr1, upd_data1});
      if (!m_ready) begin
         if (m_sweep == 2047) m_ready = 1;
         else m_sweep++;
      end
      if (btb_clear) begin
         q.delete(); m_sweep = 0; m_ready = 0;
      end
      m_pv = fetch_req; m_ph = nhit; m_pp = npc;

      @(posedge clk);
      #1;
   endtask

   initial begin
      set_idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pred_valid", pred_valid, 0);
      chk("rst_pred_hit", pred_hit, 0);
      chk("rst_pred_pc", pred_pc, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ready", ready, 0);
      chk("rst_overflow", overflow, 0);
      rst = 1'b0;
      m_ready = 0; m_sweep = 0; q.delete(); m_pv = 0; m_ph = 0; m_pp = '0;

      // Sweep after reset with no traffic, then a few idle RUN cycles
      repeat (2048) cycle();
      repeat (3) cycle();

      // Single lane-0 update, drained next cycle, then lookups
      upd_wen0 = 1; upd_addr0 = 11'h005; upd_data0 = 16'h8010;
      cycle();
      set_idle();
      cycle();
      fetch_req = 1; fetch_pc = 13'h0005;
      cycle();
      chk("dir_hit5", pred_hit, 1);
      chk("dir_pc5", pred_pc, 13'h0010);
      fetch_pc = 13'h0805;
      cycle();
      chk("dir_hit805", pred_hit, 0);
      chk("dir_pc805", pred_pc, 13'h0806);
      fetch_pc = 13'h1FFF;
      cycle();
      chk("dir_wrap", pred_pc, 13'h0000);
      set_idle();
      cycle();

      // Fill queue under fetch pressure, overflow, then drain
      fetch_req = 1; fetch_pc = 13'h0040;
      for (int i = 0; i < 5; i++) begin
         upd_wen0 = 1; upd_addr0 = 11'($urandom_range(32, 95)); upd_data0 = rnd_entry();
         upd_wen1 = 1; upd_addr1 = 11'($urandom_range(32, 95)); upd_data1 = rnd_entry();
         cycle();
      end
      set_idle();
      repeat (6) cycle();

      // Random traffic in RUN
      repeat (3000) begin
         rnd_inputs(50, 30);
         cycle();
      end
      set_idle();
      repeat (8) cycle();

      // Three queued entries, then clear under fetch
      fetch_req = 1; fetch_pc = 13'h0021;
      upd_wen0 = 1; upd_addr0 = 11'h030; upd_data0 = 16'h8111;
      upd_wen1 = 1; upd_addr1 = 11'h031; upd_data1 = 16'h8222;
      cycle();
      upd_wen1 = 0; upd_addr0 = 11'h032; upd_data0 = 16'h8333;
      cycle();
      upd_wen0 = 0; upd_wen1 = 1; upd_addr1 = 11'h033; upd_data1 = 16'h8444;
      btb_clear = 1;
      cycle();
      chk("clr_ready", ready, 0);
      set_idle();

      // Second sweep with lookups and updates arriving during it
      repeat (2050) begin
         rnd_inputs(30, 10);
         cycle();
      end
      repeat (2000) begin
         rnd_inputs(50, 30);
         cycle();
      end
      set_idle();
      repeat (8) cycle();

      // Lookup racing a same-cycle update, then while it is still queued
      fetch_req = 1; fetch_pc = 13'h0010;
      upd_wen0 = 1; upd_addr0 = 11'h010; upd_data0 = 16'h8ABC;
      cycle();
      upd_wen0 = 0;
`ifdef BTB_FWD_EN
      chk("fwd_lane_hit", pred_hit, 1);
      chk("fwd_lane_pc", pred_pc, 13'h0ABC);
`else
      chk("nofwd_lane_hit", pred_hit, 0);
      chk("nofwd_lane_pc", pred_pc, 13'h0011);
`endif
      cycle();
`ifdef BTB_FWD_EN
      chk("fwd_q_hit", pred_hit, 1);
`else
      chk("nofwd_q_hit", pred_hit, 0);
`endif
      set_idle();
      repeat (4) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
